// File: rtl/router_input_fifo.sv
// Receive end of an RTS/DCTS flit link with a first-word-fall-through input FIFO.
// Latency: RTS to DCTS 1 cycle; a flit written at an edge is visible on Data_out in the next cycle.
// Backpressure: DCTS is only raised while the FIFO is not full; reads on an empty FIFO are ignored.
// Optional: define RX_ERR_FLAGS_EN to add the sticky err[1:0] protocol-error output.
module router_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  RTS,
  output logic                  DCTS,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
`ifdef RX_ERR_FLAGS_EN
  output logic [1:0]            err,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  hs_state_t             state_q;
  hs_state_t             state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_vld;
  logic rd_vld;

  // Handshake FSM: one-cycle ACK pulse, never entered while full.
  always_comb begin
    state_d = state_q;
    wr_vld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (RTS && !full) state_d = ACK;
      end
      ACK: begin
        wr_vld  = RTS;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign DCTS   = (state_q == ACK);
  assign rd_vld = read_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_vld) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_vld) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_vld, rd_vld})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is cleared on reset so Data_out reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_vld) begin
      mem[wr_ptr_q] <= RX;
    end
  end

  assign Data_out = mem[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_CNT);

`ifdef RX_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 2'b00;
    end else begin
      if (read_en && empty)         err[0] <= 1'b1;
      if (!RTS && (state_q == ACK)) err[1] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_input_fifo.sv
// Scoreboard bench for router_input_fifo: sender model pushes expected flits, reads pop and compare.
module tb_router_input_fifo;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rx;
  logic          rts;
  logic          dcts;
  logic          read_en;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
`ifdef RX_ERR_FLAGS_EN
  logic [1:0]    err;
`endif

  logic [DW-1:0] exp_q [$];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (rx),
    .RTS      (rts),
    .DCTS     (dcts),
    .read_en  (read_en),
    .Data_out (data_out),
    .empty    (empty),
    .full     (full),
`ifdef RX_ERR_FLAGS_EN
    .err      (err),
`endif
    .count    (count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sender model: hold RTS until DCTS is seen, transfer on that edge, then drop RTS.
  task automatic send_flit(input logic [DW-1:0] d);
    bit seen;
    seen = 1'b0;
    rts  = 1'b1;
    rx   = d;
    exp_q.push_back(d);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (dcts) seen = 1'b1;
    end
    if (!seen) begin
      check_eq("dcts_timeout", {31'b0, dcts}, 32'd1);
      rts = 1'b0;
    end else begin
      tick();
      rts = 1'b0;
      rx  = '0;
      check_eq("dcts_pulse_end", {31'b0, dcts}, 32'd0);
    end
  endtask

  task automatic pop_flit();
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("head_data", data_out, e);
      check_eq("head_not_empty", {31'b0, empty}, 32'd0);
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst     = 1'b0;
    rx      = '0;
    rts     = 1'b0;
    read_en = 1'b0;
    #13;
    check_eq("rst_dcts",  {31'b0, dcts},  32'd0);
    check_eq("rst_empty", {31'b0, empty}, 32'd1);
    check_eq("rst_full",  {31'b0, full},  32'd0);
    check_eq("rst_count", {29'b0, count}, 32'd0);
    check_eq("rst_data",  data_out,       32'd0);
`ifdef RX_ERR_FLAGS_EN
    check_eq("rst_err", {30'b0, err}, 32'd0);
`endif
    #4 rst = 1'b1;
    tick();

    // T2: single flit timing
    rts = 1'b1;
    rx  = 32'hA5A5_0001;
    exp_q.push_back(32'hA5A5_0001);
    tick();
    check_eq("t2_dcts_c1", {31'b0, dcts}, 32'd1);
    tick();
    rts = 1'b0;
    check_eq("t2_dcts_c2",  {31'b0, dcts},  32'd0);
    check_eq("t2_count",    {29'b0, count}, 32'd1);
    check_eq("t2_empty",    {31'b0, empty}, 32'd0);
    pop_flit();
    check_eq("t2_empty_after", {31'b0, empty}, 32'd1);

    // Read on empty is ignored
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check_eq("rd_empty_count", {29'b0, count}, 32'd0);
    check_eq("rd_empty_empty", {31'b0, empty}, 32'd1);
`ifdef RX_ERR_FLAGS_EN
    check_eq("t6_err_rd", {30'b0, err}, 32'd1);
`endif

    // T3: fill, back-pressure, release
    for (int i = 0; i < DP; i++) send_flit(32'h3000_0000 + i);
    check_eq("t3_full",  {31'b0, full},  32'd1);
    check_eq("t3_count", {29'b0, count}, 32'd4);
    rts = 1'b1;
    rx  = 32'h3000_0004;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t3_dcts_held", {31'b0, dcts}, 32'd0);
    end
    pop_flit();
    check_eq("t3_count_3",    {29'b0, count}, 32'd3);
    check_eq("t3_dcts_still", {31'b0, dcts},  32'd0);
    tick();
    check_eq("t3_dcts_rel", {31'b0, dcts}, 32'd1);
    exp_q.push_back(32'h3000_0004);
    tick();
    rts = 1'b0;
    check_eq("t3_refull", {31'b0, full},  32'd1);
    check_eq("t3_count4", {29'b0, count}, 32'd4);
    while (exp_q.size() > 0) pop_flit();
    check_eq("t3_drained", {31'b0, empty}, 32'd1);

    // T4: read in the same cycle as a write
    send_flit(32'h4000_0001);
    send_flit(32'h4000_0002);
    check_eq("t4_count2", {29'b0, count}, 32'd2);
    rts = 1'b1;
    rx  = 32'h4000_0003;
    exp_q.push_back(32'h4000_0003);
    tick();
    check_eq("t4_dcts", {31'b0, dcts}, 32'd1);
    check_eq("t4_head", data_out, exp_q.pop_front());
    read_en = 1'b1;
    tick();
    rts     = 1'b0;
    read_en = 1'b0;
    check_eq("t4_count_same", {29'b0, count}, 32'd2);
    while (exp_q.size() > 0) pop_flit();

    // T5: ten flits with interleaved reads, pointers wrap
    send_flit(32'd1);
    send_flit(32'd2);
    for (int i = 3; i <= 10; i++) begin
      send_flit(i);
      pop_flit();
      check_eq("t5_not_empty", {31'b0, empty}, 32'd0);
    end
    while (exp_q.size() > 0) pop_flit();
    check_eq("t5_empty", {31'b0, empty}, 32'd1);

`ifdef RX_ERR_FLAGS_EN
    // T6: RTS dropped during ACK
    rts = 1'b1;
    rx  = 32'h6000_0001;
    tick();
    check_eq("t6_dcts", {31'b0, dcts}, 32'd1);
    rts = 1'b0;
    tick();
    check_eq("t6_err_ack",   {30'b0, err},   32'd3);
    check_eq("t6_count",     {29'b0, count}, 32'd0);
    tick();
    tick();
    check_eq("t6_err_sticky", {30'b0, err}, 32'd3);
`endif

    // T1: reset mid-ACK with data stored, sender keeps RTS
    send_flit(32'h1000_0001);
    send_flit(32'h1000_0002);
    rts = 1'b1;
    rx  = 32'h1000_0003;
    tick();
    check_eq("t1_dcts_pre", {31'b0, dcts}, 32'd1);
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check_eq("t1_dcts",  {31'b0, dcts},  32'd0);
    check_eq("t1_count", {29'b0, count}, 32'd0);
    check_eq("t1_empty", {31'b0, empty}, 32'd1);
    check_eq("t1_full",  {31'b0, full},  32'd0);
    check_eq("t1_data",  data_out,       32'd0);
`ifdef RX_ERR_FLAGS_EN
    check_eq("t6_err_clr", {30'b0, err}, 32'd0);
`endif
    #2 rst = 1'b1;
    tick();
    check_eq("t1_reack", {31'b0, dcts}, 32'd1);
    exp_q.push_back(32'h1000_0003);
    tick();
    rts = 1'b0;
    check_eq("t1_count1", {29'b0, count}, 32'd1);
    pop_flit();
    check_eq("t1_final_empty", {31'b0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
